// File: rtl/game_sequencer_if.sv
// game_sequencer_if: button/finish inputs and scene/strobe outputs of the game sequencer.
interface game_sequencer_if;
    logic red_button, blue_button, yellow_button, finish;
    logic [2:0] state;
    logic [1:0] song_sel, countdown;
    logic play_en, load_start, clr_score;
    modport master (
        output red_button, blue_button, yellow_button, finish,
        input state, song_sel, countdown, play_en, load_start, clr_score
    );
    modport slave (
        input red_button, blue_button, yellow_button, finish,
        output state, song_sel, countdown, play_en, load_start, clr_score
    );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: session flow controller (menu, countdown, play, pause, result) for the rhythm game.
module game_sequencer #(
    parameter int NUM_SONGS = 3,
    parameter int TICKS_PER_SEC = 1000,
    parameter int COUNT_SEC = 3,
    parameter int RESULT_TICKS = 5000
) (
    input logic clk,
    input logic rst,
    game_sequencer_if.slave io
);
    localparam int MX = TICKS_PER_SEC > RESULT_TICKS ? TICKS_PER_SEC : RESULT_TICKS;
    localparam int W = MX > 2 ? $clog2(MX) : 1;
    localparam logic [W-1:0] TICK_LAST = W'(TICKS_PER_SEC - 1);
    localparam logic [W-1:0] RES_LAST = W'(RESULT_TICKS - 1);
    localparam logic [1:0] SONG_LAST = 2'(NUM_SONGS - 1);
    localparam logic [1:0] CD_INIT = 2'(COUNT_SEC);
    typedef enum logic [2:0] {MENU = 3'd0, COUNTDOWN = 3'd1, PLAY = 3'd2, PAUSE = 3'd3, RESULT = 3'd4} state_t;
    state_t state;
    logic [W-1:0] cnt;
    logic [1:0] song_sel, countdown;
    logic play_en, load_start, clr_score;
    logic [2:0] btn, prev, armed, press;
    assign btn = {io.yellow_button, io.blue_button, io.red_button};
    // a button must be seen released after reset before it can register a press
    assign press = btn & ~prev & armed;
    assign io.state = state;
    assign io.song_sel = song_sel;
    assign io.countdown = countdown;
    assign io.play_en = play_en;
    assign io.load_start = load_start;
    assign io.clr_score = clr_score;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= MENU;
            cnt <= '0;
            song_sel <= 2'd0;
            countdown <= 2'd0;
            play_en <= 1'b0;
            load_start <= 1'b0;
            clr_score <= 1'b0;
            prev <= 3'd0;
            armed <= 3'd0;
        end else begin
            prev <= btn;
            armed <= armed | ~btn;
            load_start <= 1'b0;
            clr_score <= 1'b0;
            play_en <= 1'b0;
            case (state)
                MENU:
                    if (press[2]) begin
                        state <= COUNTDOWN;
                        clr_score <= 1'b1;
                        countdown <= CD_INIT;
                        cnt <= '0;
                    end else if (press[0] && !press[1])
                        song_sel <= song_sel == 2'd0 ? SONG_LAST : song_sel - 2'd1;
                    else if (press[1] && !press[0])
                        song_sel <= song_sel == SONG_LAST ? 2'd0 : song_sel + 2'd1;
                COUNTDOWN:
                    if (press[2]) begin
                        state <= MENU;
                        countdown <= 2'd0;
                    end else if (cnt == TICK_LAST) begin
                        cnt <= '0;
                        countdown <= countdown - 2'd1;
                        if (countdown == 2'd1) begin
                            state <= PLAY;
                            load_start <= 1'b1;
                        end
                    end else
                        cnt <= cnt + 1'b1;
                PLAY:
                    if (io.finish) begin
                        state <= RESULT;
                        cnt <= '0;
                    end else if (press[2])
                        state <= PAUSE;
                    else
                        play_en <= 1'b1;
                PAUSE:
                    if (press[2])
                        state <= PLAY;
                    else if (press[0])
                        state <= MENU;
                RESULT:
                    if (press[2] || cnt == RES_LAST)
                        state <= MENU;
                    else
                        cnt <= cnt + 1'b1;
                default: begin
                    state <= MENU;
                    cnt <= '0;
                    song_sel <= 2'd0;
                    countdown <= 2'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed and randomized checks of game_sequencer against a cycle-count reference model.
module tb_game_sequencer;
    localparam int N = 3, T = 4, C = 3, RT = 8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    game_sequencer_if io();
    game_sequencer #(.NUM_SONGS(N), .TICKS_PER_SEC(T), .COUNT_SEC(C), .RESULT_TICKS(RT)) dut (
        .clk(clk), .rst(rst), .io(io.slave)
    );
    always #5 clk = ~clk;

    int vectors = 0, errors = 0;
    int m_state, m_sel, m_cd, el, rel;
    bit m_play, m_load, m_clr;
    bit [2:0] m_prev, m_armed;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Countdown and result are modelled by elapsed cycles since entering the scene.
    task automatic model_step();
        bit [2:0] b, p;
        int old;
        b = {io.yellow_button, io.blue_button, io.red_button};
        if (!rst) begin
            m_state = 0; m_sel = 0; m_cd = 0; el = 0; rel = 0;
            m_play = 0; m_load = 0; m_clr = 0; m_prev = 0; m_armed = 0;
            return;
        end
        p = b & ~m_prev & m_armed;
        m_prev = b;
        m_armed |= ~b;
        old = m_state;
        m_load = 0;
        m_clr = 0;
        case (m_state)
            0: if (p[2]) begin m_state = 1; m_clr = 1; el = 0; end
               else if (p[0] && !p[1]) m_sel = (m_sel + N - 1) % N;
               else if (p[1] && !p[0]) m_sel = (m_sel + 1) % N;
            1: if (p[2]) m_state = 0;
               else begin
                   el++;
                   if (el == C * T) begin m_state = 2; m_load = 1; end
               end
            2: if (io.finish) begin m_state = 4; rel = 0; end
               else if (p[2]) m_state = 3;
            3: if (p[2]) m_state = 2;
               else if (p[0]) m_state = 0;
            4: begin rel++; if (p[2] || rel == RT) m_state = 0; end
            default: m_state = 0;
        endcase
        m_play = old == 2 && m_state == 2;
        m_cd = m_state == 1 ? C - el / T : 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("state", io.state, m_state);
        check("song_sel", io.song_sel, m_sel);
        check("countdown", io.countdown, m_cd);
        check("play_en", io.play_en, m_play);
        check("load_start", io.load_start, m_load);
        check("clr_score", io.clr_score, m_clr);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_btn(input int b, input logic v);
        if (b == 0) io.red_button = v;
        else if (b == 1) io.blue_button = v;
        else io.yellow_button = v;
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        step();
        set_btn(b, 1'b0);
        step();
    endtask

    initial begin
        io.red_button = 0; io.blue_button = 0; io.yellow_button = 0; io.finish = 0;
        rst = 0;
        run(2);
        check("reset_state", io.state, 0);
        check("reset_song", io.song_sel, 0);
        rst = 1;
        step();
        press(0);
        check("menu_r1", io.song_sel, 2);
        press(0);
        check("menu_r2", io.song_sel, 1);
        press(1);
        check("menu_b", io.song_sel, 2);
        check("menu_state", io.state, 0);
        io.red_button = 1; io.blue_button = 1;
        step();
        check("menu_rb", io.song_sel, 2);
        io.red_button = 0; io.blue_button = 0;
        step();
        // countdown 3,2,1 for T cycles each, PLAY exactly C*T cycles after the Y press
        io.yellow_button = 1;
        step();
        check("cd_clr", io.clr_score, 1);
        check("cd_start", io.countdown, 3);
        io.yellow_button = 0;
        for (int i = 1; i < C * T; i++) begin
            step();
            check("cd_digit", io.countdown, 3 - i / T);
        end
        step();
        check("play_entry", io.state, 2);
        check("play_load", io.load_start, 1);
        check("play_en_late", io.play_en, 0);
        step();
        check("play_en", io.play_en, 1);
        io.finish = 1; io.yellow_button = 1;
        step();
        check("finish_prio", io.state, 4);
        io.finish = 0; io.yellow_button = 0;
        run(RT - 1);
        check("result_hold", io.state, 4);
        step();
        check("result_exit", io.state, 0);
        check("result_song", io.song_sel, 2);
        press(2);
        run(C * T - 1);
        check("play_again", io.state, 2);
        io.yellow_button = 1; step(); io.yellow_button = 0;
        check("pause", io.state, 3);
        check("pause_en", io.play_en, 0);
        step();
        io.yellow_button = 1; step(); io.yellow_button = 0;
        check("resume", io.state, 2);
        check("resume_load", io.load_start, 0);
        step();
        press(2);
        check("pause2", io.state, 3);
        io.red_button = 1; step(); io.red_button = 0;
        check("quit", io.state, 0);
        step();
        press(2);
        run(3);
        check("abort_digit", io.countdown, 2);
        io.yellow_button = 1; step(); io.yellow_button = 0;
        check("abort_state", io.state, 0);
        check("abort_cd", io.countdown, 0);
        run(C * T + 2);
        check("abort_stays", io.state, 0);
        press(0);
        press(2);
        run(C * T + 1);
        check("pre_rst_play", io.state, 2);
        io.red_button = 1; io.blue_button = 1; io.yellow_button = 1;
        rst = 0;
        step();
        check("rst_state", io.state, 0);
        check("rst_song", io.song_sel, 0);
        check("rst_en", io.play_en, 0);
        rst = 1;
        run(3);
        check("held_state", io.state, 0);
        check("held_song", io.song_sel, 0);
        io.red_button = 0; io.blue_button = 0; io.yellow_button = 0;
        step();
        io.yellow_button = 1; step(); io.yellow_button = 0;
        check("repress", io.state, 1);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(3) == 0) io.red_button = ~io.red_button;
            if ($urandom_range(3) == 0) io.blue_button = ~io.blue_button;
            if ($urandom_range(15) == 0) io.yellow_button = ~io.yellow_button;
            io.finish = $urandom_range(15) == 0;
            rst = $urandom_range(499) != 0;
            step();
        end
        rst = 1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller for the LED-matrix rhythm game.
- Sequences the session: song menu -> countdown -> play -> pause/result -> menu.
- Drives the selected song, the scene state consumed by the panel driver and menu renderer, and the one-shot start/clear strobes for the note shifter and score counter.
- Runs on the divided panel clock, alongside the note shifter and button judge.

Parameters:
- NUM_SONGS, 3, number of selectable songs; song_sel ranges 0..NUM_SONGS-1 (max 4).
- TICKS_PER_SEC, 1000, clk cycles per countdown step.
- COUNT_SEC, 3, countdown start value (1..3).
- RESULT_TICKS, 5000, clk cycles the result screen is held before returning to the menu.

Ports:
- clk  in  1  divided system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-low reset.
- red_button  in  1  raw level, already synchronous to clk.
- blue_button  in  1  raw level, already synchronous to clk.
- yellow_button  in  1  raw level, already synchronous to clk.
- finish  in  1  level from the note shifter; high means the song chart is exhausted.
- state  out  3  0=MENU, 1=COUNTDOWN, 2=PLAY, 3=PAUSE, 4=RESULT.
- song_sel  out  2  currently highlighted or confirmed song.
- countdown  out  2  remaining countdown digit; 0 outside COUNTDOWN.
- play_en  out  1  high only in PLAY; gates note shifting and judging.
- load_start  out  1  one-cycle strobe; the shifter loads song_sel's chart.
- clr_score  out  1  one-cycle strobe; clears score and combo.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=MENU, song_sel=0, countdown=0, play_en=0, load_start=0, clr_score=0.
  - All counters and button-history registers are cleared to 0.
  - Reset applies from any state, including mid-countdown or mid-play.
- Edge detect:
  - A press (R, B, Y) is button=1 with previous-cycle sample=0. One press per assertion.
  - Holding a button produces no repeat.
  - History registers update every cycle, in every state.
- MENU:
  - R press: song_sel-1, wrapping 0 -> NUM_SONGS-1.
  - B press: song_sel+1, wrapping NUM_SONGS-1 -> 0.
  - R and B pressed in the same cycle: song_sel unchanged.
  - Y press: go to COUNTDOWN. clr_score=1 for exactly that cycle, countdown=COUNT_SEC, tick counter=0.
  - Y has priority over R/B in the same cycle; song_sel is not changed in that cycle.
- COUNTDOWN:
  - The tick counter increments every cycle.
  - When the counter reaches TICKS_PER_SEC-1, it wraps to 0 and countdown decrements.
  - If countdown is 1 when the counter wraps: go to PLAY, countdown=0, load_start=1 for that one cycle, play_en=1 from the next cycle.
  - Y press aborts: go to MENU, countdown=0, no load_start.
  - R and B are ignored.
  - Total latency from the Y press to the first PLAY cycle is COUNT_SEC*TICKS_PER_SEC cycles.
- PLAY:
  - play_en=1.
  - finish=1 goes to RESULT; the result timer is set to 0.
  - Y press goes to PAUSE.
  - finish has priority over a Y press in the same cycle.
  - R and B are not interpreted here; they belong to the button judge.
- PAUSE:
  - play_en=0. finish is ignored.
  - Y press resumes to PLAY with no load_start and no clr_score.
  - R press quits to MENU.
  - Y and R pressed in the same cycle: Y wins (resume).
- RESULT:
  - play_en=0.
  - The timer increments each cycle. At RESULT_TICKS-1, go to MENU.
  - A Y press goes to MENU immediately.
  - song_sel is retained in RESULT and in every return to MENU.
- Strobes:
  - load_start and clr_score are registered, never high for two consecutive cycles, and never high together.
- Counter widths: $clog2 of the larger of TICKS_PER_SEC and RESULT_TICKS. No overflow is reachable.
- Illegal state encodings (5-7) go to MENU on the next cycle with all outputs at their reset values.

Test Plan:
- Reset, then R press, R press, B press in MENU (NUM_SONGS=3) -> song_sel sequence 2, 1, 2. State stays 0.
- Set TICKS_PER_SEC=4, COUNT_SEC=3. Y press in MENU -> clr_score high 1 cycle; countdown reads 3, 2, 1 for 4 cycles each; then state=2 with load_start high 1 cycle, 12 cycles after the Y press; play_en=1 on the next cycle.
- In PLAY, assert finish and a Y press in the same cycle -> state=4, not 3. With RESULT_TICKS=8, state=0 after 8 cycles and song_sel is unchanged.
- In PLAY, Y press -> state=3, play_en=0. Y press again -> state=2 with no load_start. Then enter PAUSE and press R -> state=0.
- Y press at countdown=2 -> state=0, countdown=0, load_start never asserts.
- Drive rst=0 for one cycle mid-PLAY with buttons held high -> all outputs at reset values. A held button does not register a press after reset until it is released and pressed again.
